// File: rtl/regfile_pkg.sv
// Shared CPU register-file types and constants.
// Optional same-cycle bypass is enabled with REGFILE_BYPASS_EN.
package regfile_pkg;

  typedef logic        Bit_t;
  typedef logic [31:0] Word_t;
  typedef logic [4:0]  Reg_addr_t;

  localparam Bit_t  ENABLE    = 1'b1;
  localparam Bit_t  DISABLE   = 1'b0;
  localparam Word_t ZERO_WORD = 32'h0;
  localparam int    REG_NUM   = 32;

  localparam logic [0:0] RF_INIT  = 1'b0;
  localparam logic [0:0] RF_READY = 1'b1;

endpackage

// File: rtl/hilo_reg.sv
// HI/LO multiply-divide result registers.
// REGFILE_BYPASS_EN forwards write data to the outputs in the write cycle.
module hilo_reg
  import regfile_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hi_wdata,
  input  logic [31:0] lo_wdata,
  output logic [31:0] hi_data,
  output logic [31:0] lo_data
);

  Word_t hi_q, hi_d;
  Word_t lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (hi_we == ENABLE) hi_d = hi_wdata;
    if (lo_we == ENABLE) lo_d = lo_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q <= ZERO_WORD;
      lo_q <= ZERO_WORD;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign hi_data = hi_d;
  assign lo_data = lo_d;
`else
  assign hi_data = hi_q;
  assign lo_data = lo_q;
`endif

endmodule

// File: rtl/regfile.sv
// Two-read/one-write integer register file with post-reset clear sequencer.
// REGFILE_BYPASS_EN forwards same-cycle write data to matching reads.
module regfile
  import regfile_pkg::*;
#(
  parameter int NUM_REGS    = REG_NUM,
  parameter int INIT_CYCLES = NUM_REGS
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ready,
  input  logic        reg1_read,
  input  logic [4:0]  reg1_addr,
  output logic [31:0] reg1_data,
  input  logic        reg2_read,
  input  logic [4:0]  reg2_addr,
  output logic [31:0] reg2_data,
  input  logic        wreg_write,
  input  logic [4:0]  wreg_addr,
  input  logic [31:0] wreg_data,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hi_wdata,
  input  logic [31:0] lo_wdata,
  output logic [31:0] hi_data,
  output logic [31:0] lo_data
);

  localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  Word_t     mem [NUM_REGS];
  Bit_t      mem_we;
  Reg_addr_t mem_waddr;
  Word_t     mem_wdata;
  Bit_t      in_init;

  assign in_init = (state_q == RF_INIT);
  assign ready   = (state_q == RF_READY);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_INIT: begin
        if (cnt_q == CNT_LAST) state_d = RF_READY;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RF_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear port and write-back port share the single array write port.
  always_comb begin
    mem_we    = DISABLE;
    mem_waddr = wreg_addr;
    mem_wdata = wreg_data;
    if (rst_n) begin
      unique case (1'b1)
        in_init: begin
          mem_we    = ENABLE;
          mem_waddr = 5'(cnt_q);
          mem_wdata = ZERO_WORD;
        end
        default: begin
          mem_we = wreg_write && (wreg_addr != 5'd0);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  function automatic Bit_t rd_ok(input logic en, input Reg_addr_t a);
    return en && (a != 5'd0) && ready;
  endfunction

  always_comb begin
    reg1_data = ZERO_WORD;
    if (rd_ok(reg1_read, reg1_addr)) begin
      reg1_data = mem[reg1_addr];
`ifdef REGFILE_BYPASS_EN
      if (wreg_write && (wreg_addr == reg1_addr)) reg1_data = wreg_data;
`endif
    end
  end

  always_comb begin
    reg2_data = ZERO_WORD;
    if (rd_ok(reg2_read, reg2_addr)) begin
      reg2_data = mem[reg2_addr];
`ifdef REGFILE_BYPASS_EN
      if (wreg_write && (wreg_addr == reg2_addr)) reg2_data = wreg_data;
`endif
    end
  end

  hilo_reg u_hilo (
    .clk      (clk),
    .rst_n    (rst_n),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata),
    .hi_data  (hi_data),
    .lo_data  (lo_data)
  );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed table, reset sequences
// and random traffic against a behavioural register-file model.
module tb_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int NINIT = 32;

  logic        clk;
  logic        rst_n;
  logic        ready;
  logic        reg1_read, reg2_read;
  logic [4:0]  reg1_addr, reg2_addr;
  logic [31:0] reg1_data, reg2_data;
  logic        wreg_write;
  logic [4:0]  wreg_addr;
  logic [31:0] wreg_data;
  logic        hi_we, lo_we;
  logic [31:0] hi_wdata, lo_wdata;
  logic [31:0] hi_data, lo_data;

  regfile dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ready      (ready),
    .reg1_read  (reg1_read),
    .reg1_addr  (reg1_addr),
    .reg1_data  (reg1_data),
    .reg2_read  (reg2_read),
    .reg2_addr  (reg2_addr),
    .reg2_data  (reg2_data),
    .wreg_write (wreg_write),
    .wreg_addr  (wreg_addr),
    .wreg_data  (wreg_data),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .hi_wdata   (hi_wdata),
    .lo_wdata   (lo_wdata),
    .hi_data    (hi_data),
    .lo_data    (lo_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: register contents, HI/LO, and edges since reset.
  logic [31:0] m_mem [32];
  logic [31:0] m_hi, m_lo;
  int          m_edges;

  function automatic bit m_ready();
    return m_edges >= NINIT;
  endfunction

  function automatic logic [31:0] exp_rd(logic en, logic [4:0] a);
    if (!en || a == 5'd0 || !m_ready()) return 32'h0;
    if (BYP && wreg_write && wreg_addr == a) return wreg_data;
    return m_mem[a];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_edges = 0;
      m_hi = 32'h0;
      m_lo = 32'h0;
    end else begin
      if (!m_ready()) begin
        m_edges++;
        if (m_ready()) for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
      end else if (wreg_write && wreg_addr != 5'd0) begin
        m_mem[wreg_addr] = wreg_data;
      end
      if (hi_we) m_hi = hi_wdata;
      if (lo_we) m_lo = lo_wdata;
    end
  endtask

  // Check all outputs against the model, then advance one clock.
  task automatic tick();
    #1;
    chk("ready", {31'h0, ready}, {31'h0, m_ready()});
    chk("reg1_data", reg1_data, exp_rd(reg1_read, reg1_addr));
    chk("reg2_data", reg2_data, exp_rd(reg2_read, reg2_addr));
    chk("hi_data", hi_data, (BYP && hi_we) ? hi_wdata : m_hi);
    chk("lo_data", lo_data, (BYP && lo_we) ? lo_wdata : m_lo);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_in();
    reg1_read = 0; reg1_addr = 0;
    reg2_read = 0; reg2_addr = 0;
    wreg_write = 0; wreg_addr = 0; wreg_data = 0;
    hi_we = 0; lo_we = 0; hi_wdata = 0; lo_wdata = 0;
  endtask

  typedef struct {
    logic        rd1;
    logic [4:0]  a1;
    logic        rd2;
    logic [4:0]  a2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        hwe;
    logic        lwe;
    logic [31:0] hd;
    logic [31:0] ld;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t tbl [7];

  task automatic wait_ready(string tag);
    int k;
    k = 0;
    while (k < 40) begin
      #1;
      if (k == NINIT - 1) chk({tag, "_ready_lo"}, {31'h0, ready}, 32'h0);
      if (k == NINIT)     chk({tag, "_ready_hi"}, {31'h0, ready}, 32'h1);
      if (k >= NINIT) break;
      tick();
      k++;
    end
  endtask

  initial begin
    logic [31:0] v_aa, v_hi, v_lo, v_h2;
    v_aa = BYP ? 32'hAA : 32'h1;
    v_hi = BYP ? 32'h11 : 32'h0;
    v_lo = BYP ? 32'h22 : 32'h0;
    v_h2 = BYP ? 32'h33 : 32'h11;
    //         rd1 a1 rd2 a2 we wa wd            hwe lwe hd     ld     e1            e2            ehi    elo
    tbl[0] = '{0, 7, 0, 7, 1, 7, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0, 32'h0,        32'h0,        32'h0, 32'h0};
    tbl[1] = '{1, 7, 0, 7, 1, 0, 32'h12345678, 0, 0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0,        32'h0, 32'h0};
    tbl[2] = '{1, 0, 1, 7, 1, 9, 32'h1,        0, 0, 32'h0, 32'h0, 32'h0,        32'hDEADBEEF, 32'h0, 32'h0};
    tbl[3] = '{1, 9, 1, 9, 1, 9, 32'hAA,       1, 1, 32'h11, 32'h22, v_aa,       v_aa,         v_hi,  v_lo};
    tbl[4] = '{1, 9, 0, 9, 0, 0, 32'h0,        0, 0, 32'h0, 32'h0, 32'hAA,       32'h0,        32'h11, 32'h22};
    tbl[5] = '{0, 7, 1, 5, 0, 0, 32'h0,        1, 0, 32'h33, 32'h0, 32'h0,       32'h0,        v_h2,  32'h22};
    tbl[6] = '{1, 7, 1, 9, 0, 0, 32'h0,        0, 0, 32'h0, 32'h0, 32'hDEADBEEF, 32'hAA,       32'h33, 32'h22};

    idle_in();
    rst_n = 0;
    repeat (3) @(posedge clk);
    model_edge();
    #1;
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_hi", hi_data, 32'h0);
    chk("rst_lo", lo_data, 32'h0);

    // Release reset and read r5 throughout the clear.
    rst_n = 1;
    reg1_read = 1; reg1_addr = 5'd5;
    wait_ready("init");

    for (int i = 0; i < 32; i++) begin
      reg1_read = 1; reg1_addr = 5'(i);
      reg2_read = 1; reg2_addr = 5'(31 - i);
      #1;
      chk("clr_r1", reg1_data, 32'h0);
      tick();
    end

    for (int i = 0; i < 7; i++) begin
      reg1_read = tbl[i].rd1; reg1_addr = tbl[i].a1;
      reg2_read = tbl[i].rd2; reg2_addr = tbl[i].a2;
      wreg_write = tbl[i].we; wreg_addr = tbl[i].wa;
      wreg_data = tbl[i].wd;
      hi_we = tbl[i].hwe; lo_we = tbl[i].lwe;
      hi_wdata = tbl[i].hd; lo_wdata = tbl[i].ld;
      #1;
      chk($sformatf("tbl%0d_r1", i), reg1_data, tbl[i].e1);
      chk($sformatf("tbl%0d_r2", i), reg2_data, tbl[i].e2);
      chk($sformatf("tbl%0d_hi", i), hi_data, tbl[i].ehi);
      chk($sformatf("tbl%0d_lo", i), lo_data, tbl[i].elo);
      tick();
    end

    for (int i = 0; i < 400; i++) begin
      reg1_read = 1'($urandom_range(0, 3) != 0);
      reg2_read = 1'($urandom_range(0, 3) != 0);
      reg1_addr = 5'($urandom_range(0, 7));
      reg2_addr = 5'($urandom);
      wreg_write = 1'($urandom);
      wreg_addr = 5'($urandom_range(0, 7));
      wreg_data = $urandom;
      hi_we = ($urandom_range(0, 3) == 0);
      lo_we = ($urandom_range(0, 3) == 0);
      hi_wdata = $urandom;
      lo_wdata = $urandom;
      tick();
    end

    // Reset racing a write, then a reset part-way through the clear.
    idle_in();
    wreg_write = 1; wreg_addr = 5'd3; wreg_data = 32'h77;
    hi_we = 1; hi_wdata = 32'h5A5A;
    tick();
    wreg_data = 32'h55;
    hi_we = 0;
    rst_n = 0;
    tick();
    idle_in();
    chk("rst2_hi", hi_data, 32'h0);
    rst_n = 1;
    repeat (10) tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    wait_ready("reinit");
    reg1_read = 1; reg1_addr = 5'd3;
    #1;
    chk("r3_after_rst", reg1_data, 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
